// File: rtl/serial_deser_if.sv
// serial_deser_if: serial input / parallel word output bundle for serial_deser.
// master drives the serial side and observes the word; slave is the deserializer.
interface serial_deser_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  CE;
  logic                  D;
  logic                  BITSLIP;
  logic [DATA_WIDTH-1:0] Q;
  logic                  Q_VLD;

  modport master (
    output CE,
    output D,
    output BITSLIP,
    input  Q,
    input  Q_VLD
  );

  modport slave (
    input  CE,
    input  D,
    input  BITSLIP,
    output Q,
    output Q_VLD
  );
endinterface

// File: rtl/serial_deser.sv
// serial_deser: bit-serial to parallel deserializer, MSB-first, with bit slip.
// One bit of D is captured per enabled clock; every N enabled non-slip cycles a
// word is presented on Q with a one-cycle Q_VLD strobe.
// Optional feature macro SERIAL_DESER_FORCE_EN: adds reset-free override
// registers Q_f / Q_v (written from the host side) that replace Q when Q_f=1.
module serial_deser #(
  parameter int unsigned                DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0]      INIT_Q     = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  serial_deser_if.slave      bus
);

  localparam int unsigned SR_W  = DATA_WIDTH - 1;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  // Reject unsupported word widths at elaboration
  generate
    if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_bad_width
      $error("serial_deser: DATA_WIDTH must be in 2..8");
    end
  endgenerate

  logic [SR_W-1:0]       r_sr;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_q_vld;

  logic [SR_W-1:0]       w_sr_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_q_nxt;
  logic                  w_q_vld_nxt;
  logic [DATA_WIDTH-1:0] w_word;

  // Candidate word: the N-1 buffered bits followed by the current bit
  assign w_word = {r_sr, bus.D};

  // Next-state: shift on every enabled cycle; slip holds the counter so the
  // word boundary moves one bit later
  always_comb begin
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_q_vld_nxt = 1'b0;
    if (bus.CE) begin
      w_sr_nxt = SR_W'(w_word);
      if (!bus.BITSLIP) begin
        if (r_cnt == CNT_LAST) begin
          w_q_nxt     = w_word;
          w_q_vld_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_q     <= INIT_Q;
      r_q_vld <= 1'b0;
    end else begin
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_q_vld <= w_q_vld_nxt;
    end
  end

  assign bus.Q_VLD = r_q_vld;

`ifdef SERIAL_DESER_FORCE_EN
  // Host-side override; deliberately reset-free, starts at 0
  logic                  Q_f = 1'b0;
  logic [DATA_WIDTH-1:0] Q_v = '0;

  assign bus.Q = Q_f ? Q_v : r_q;
`else
  assign bus.Q = r_q;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed vector bench for serial_deser (N=4, INIT_Q=4'hA).
module tb_serial_deser;

  localparam int unsigned N = 4;

  logic clk;
  logic rst_n;

  serial_deser_if #(.DATA_WIDTH(N)) bus ();

  serial_deser #(
    .DATA_WIDTH (N),
    .INIT_Q     (4'hA)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       ce;
    logic       slip;
    logic       d;
    logic [3:0] q;
    logic       vld;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  function automatic vec_t mk(logic r, logic c, logic s, logic dd, logic [3:0] eq, logic ev);
    vec_t v;
    v.rst_n = r; v.ce = c; v.slip = s; v.d = dd; v.q = eq; v.vld = ev;
    return v;
  endfunction

  task automatic check(string name, logic [3:0] exp_q, logic exp_vld);
    n_total++;
    if (bus.Q === exp_q) n_pass++;
    else $display("FAIL %s: Q got %h expected %h", name, bus.Q, exp_q);
    n_total++;
    if (bus.Q_VLD === exp_vld) n_pass++;
    else $display("FAIL %s: Q_VLD got %b expected %b", name, bus.Q_VLD, exp_vld);
  endtask

  task automatic drive(logic r, logic c, logic s, logic dd);
    @(negedge clk);
    rst_n       = r;
    bus.CE      = c;
    bus.BITSLIP = s;
    bus.D       = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] stream;
    int          vld_cnt;
    n_pass  = 0;
    n_total = 0;
    bus.CE = 1'b0; bus.D = 1'b0; bus.BITSLIP = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Reset value visible before any clock edge
    check("reset_async", 4'hA, 1'b0);

    // Basic word 1,0,1,1
    vecs.push_back(mk(1, 1, 0, 1, 4'hA, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'hA, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'hA, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'hB, 1));
    vecs.push_back(mk(1, 0, 0, 0, 4'hB, 0));
    // Same word with CE=0 gaps; D on disabled cycles is junk
    vecs.push_back(mk(1, 1, 0, 1, 4'hB, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'hB, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'hB, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'hB, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'hB, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'hB, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'hB, 1));
    vecs.push_back(mk(1, 0, 0, 0, 4'hB, 0));
    // Stream 1,1,0,0,... with slip on the second bit: boundary moves one bit
    // later, words become 1,0,0,1
    vecs.push_back(mk(1, 1, 0, 1, 4'hB, 0));
    vecs.push_back(mk(1, 1, 1, 1, 4'hB, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'hB, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'hB, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'h9, 1));
    vecs.push_back(mk(1, 1, 0, 1, 4'h9, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'h9, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'h9, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'h9, 1));
    // Slip in the last-bit cycle suppresses completion; next enabled
    // non-slip cycle completes with the latest 4 bits 0,0,1,1
    vecs.push_back(mk(1, 1, 0, 1, 4'h9, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'h9, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'h9, 0));
    vecs.push_back(mk(1, 1, 1, 1, 4'h9, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'h3, 1));
    // Reset mid-word: 2 bits, reset, then 0,1,1,0
    vecs.push_back(mk(1, 1, 0, 1, 4'h3, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'h3, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'hA, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'hA, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'hA, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4'hA, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'h6, 1));
    vecs.push_back(mk(1, 0, 0, 0, 4'h6, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].ce, vecs[i].slip, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].q, vecs[i].vld);
    end

    // Continuous CE: words 5,E,2,9 back to back, strobe every 4th cycle
    stream  = 16'h5E29;
    vld_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] wq;
      drive(1'b1, 1'b1, 1'b0, stream[15-i]);
      if (bus.Q_VLD === 1'b1) vld_cnt++;
      case (i / 4)
        0: wq = (i % 4 == 3) ? 4'h5 : 4'h6;
        1: wq = (i % 4 == 3) ? 4'hE : 4'h5;
        2: wq = (i % 4 == 3) ? 4'h2 : 4'hE;
        default: wq = (i % 4 == 3) ? 4'h9 : 4'h2;
      endcase
      check($sformatf("burst%0d", i), wq, (i % 4 == 3) ? 1'b1 : 1'b0);
    end
    n_total++;
    if (vld_cnt == 4) n_pass++;
    else $display("FAIL burst_strobes: got %0d expected 4", vld_cnt);

    // Asynchronous reset asserted between edges
    @(negedge clk);
    bus.CE = 1'b1; bus.D = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_midcycle", 4'hA, 1'b0);

`ifdef SERIAL_DESER_FORCE_EN
    // Override replaces Q while words keep completing underneath
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    dut.Q_v = 4'h5;
    dut.Q_f = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("force0", 4'h5, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("force_word", 4'h5, 1'b1);
    dut.Q_f = 1'b0;
    #1;
    check("force_release", 4'hB, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
